uart_tx_framer: RTL and testbench
=================================

# uart_tx_framer

Packet framer that sits directly upstream of the UART transmitter and drives its `tx_data`/`tx_valid`/`tx_ready` interface. It buffers payload bytes from a valid/ready byte stream and closes a packet on `in_last` or when the packet reaches `MAX_LEN`. Each committed packet goes out as a frame: sync byte, length byte, payload, and an optional checksum. Between bytes it follows the transmitter's one-byte-at-a-time handshake.

## Interface
- `DEPTH`, 64: payload FIFO depth in bytes; power of two, ≥ `MAX_LEN`.
- `MAX_LEN`, 32: maximum payload bytes per packet, 1..255; longer input is auto-split.
- `LEN_Q`, 4: number of committed packets that can be queued (length queue depth).
- `SYNC_BYTE`, 8'hA5: first byte of every frame.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_data` in 8: payload byte.
- `in_valid` in 1: `in_data` valid.
- `in_last` in 1: qualifies `in_data` as the final byte of the packet.
- `in_ready` out 1: byte accepted on a cycle with `in_valid && in_ready`.
- `tx_data` out 8: byte to the transmitter.
- `tx_valid` out 1: single-cycle pulse requesting transmission of `tx_data`.
- `tx_ready` in 1: transmitter idle and able to accept a byte.
- `busy` out 1: frame in progress (state ≠ IDLE).
- `frame_done` out 1: one-cycle pulse after the last byte of a frame is handed off.

## Operation
- Payload FIFO: `DEPTH` bytes with registered pointers. Simultaneous push and pop are legal; the count is unchanged.
- Length queue: `LEN_Q` entries of 8 bits.
  - A running length counter increments per accepted byte.
  - The counter's final value is pushed on accept with `in_last`, or when the count reaches `MAX_LEN`. The counter then clears.
  - A zero-length packet cannot occur.
- `in_ready` = FIFO not full AND length queue not full. Combinational from registered counts.
- The FSM, which registers `tx_data` and `tx_valid`, has these states:
  - IDLE: when the length queue is non-empty and `tx_ready`=1, pop the length into `len_r`, clear `sum_r`, issue `SYNC_BYTE`, and go to SYNC.
  - SYNC → LEN: issue `len_r`; `sum_r += len_r`.
  - LEN → PAY: issue a FIFO pop byte; `sum_r += byte`; decrement the remaining count.
  - PAY: repeat until the remaining count is 0, then go to CSUM, or to IDLE when the checksum is compiled out.
  - CSUM: issue `sum_r`, then go to IDLE.
- Byte handshake, used for every issued byte:
  - ISSUE: `tx_valid`=1 for exactly one cycle.
  - WAIT_LO: wait for `tx_ready`=0.
  - WAIT_HI: wait for `tx_ready`=1.
  - The next byte is issued only from WAIT_HI with `tx_ready`=1.
- `frame_done` pulses on the cycle the FSM returns to IDLE.
- Arithmetic: `sum_r` is an 8-bit sum that wraps mod 256. The remaining count is 8 bits. FIFO pointers are log2(`DEPTH`) bits and wrap naturally.
- Input and output run concurrently. The FIFO keeps filling with the next packet during transmission.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `busy`=0, `frame_done`=0, state IDLE, FIFO and queue empty, `in_ready`=1 after release.
- Asynchronous reset mid-frame aborts immediately:
  - All buffered bytes and queued lengths are discarded.
  - No partial checksum is emitted.
  - The transmitter shares `rst_n`.
- Latency from the input side:
  - `in_last` accepted at edge N.
  - Length queue is non-empty after N.
  - `tx_valid` is high in the cycle after edge N+1, provided `tx_ready`=1.
- Latency between bytes: `tx_valid` rises 1 cycle after `tx_ready` returns high.
- `tx_valid` is never high on two consecutive cycles.
- `in_last` on the byte that also reaches `MAX_LEN` commits exactly one packet.
- A FIFO pop in PAY while a push occurs with the FIFO full is legal: `in_ready` is still 0 that cycle, with no lookahead.

## Configuration
- `UART_FRAMER_CSUM_EN` defined:
  - CSUM state is present.
  - Frame = SYNC, LEN, payload, and `(LEN + Σpayload) mod 256`.
- `UART_FRAMER_CSUM_EN` undefined:
  - CSUM state and `sum_r` are removed.
  - PAY goes directly to IDLE.
  - Frame = SYNC, LEN, payload.

## Test plan
- Basic frame, with the checksum enabled:
  - Stimulus: push 01, 02, 03 (`in_last` on 03), transmitter at 50 MHz / 100 kbaud.
  - Response: serial decodes A5 03 01 02 03 09; `frame_done` pulses once; `busy` is 0 after.
- Basic frame, with the checksum disabled:
  - Stimulus: same input.
  - Response: A5 03 01 02 03 only.
- Auto-split:
  - Stimulus: 40 bytes 00..27 without `in_last` except on byte 27.
  - Response: frames of length 0x20 then 0x08, with correct sums, back-to-back.
- Backpressure:
  - Stimulus: hold `tx_ready`=0; push 64 bytes in 2 packets.
  - Response: `in_ready` drops at FIFO full (count 64); no `tx_valid`. Release → both frames emitted in order, with no lost bytes.
- Queue full:
  - Stimulus: stalled transmitter; push 4 one-byte packets.
  - Response: `in_ready`=0 after the 4th `in_last`; the 5th byte is not accepted until the first frame pops its length.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 asynchronously during the PAY state.
  - Response: `tx_valid`/`busy` go 0 immediately; after release, a new packet 7E (`in_last`) yields A5 01 7E 7F.

Source files
------------

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: buffers a valid/ready byte stream into packets and emits each
// committed packet as SYNC, LEN, payload [, checksum], one byte at a time, over
// the transmitter's tx_valid/tx_ready handshake.
// Optional feature macro: UART_FRAMER_CSUM_EN appends (LEN + sum(payload)) mod 256.
//
// state | meaning
// IDLE  | no frame; waits for a queued length and an idle transmitter
// SYNC  | sync byte issued
// LEN   | length byte issued
// PAY   | payload byte issued; rem_r counts bytes still to send
// CSUM  | checksum byte issued (only with UART_FRAMER_CSUM_EN)
//
// Each issued byte walks the handshake ISSUE -> WAIT_LO -> WAIT_HI. After the
// last byte of a frame the FSM returns to IDLE as soon as the transmitter has
// taken it (tx_ready low); IDLE itself waits for tx_ready before the next SYNC.
module uart_tx_framer #(
    parameter int         DEPTH     = 64,
    parameter int         MAX_LEN   = 32,
    parameter int         LEN_Q     = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int         AW        = $clog2(DEPTH);
    localparam int         QW        = (LEN_Q > 1) ? $clog2(LEN_Q) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [QW:0] LEN_Q_C  = (QW+1)'(LEN_Q);
    localparam logic [QW-1:0] LQ_LAST = QW'(LEN_Q - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
`ifdef UART_FRAMER_CSUM_EN
        S_CSUM,
`endif
        S_PAY
    } state_t;

    typedef enum logic [1:0] {
        H_ISSUE,
        H_WAIT_LO,
        H_WAIT_HI
    } hs_t;

    state_t state;
    hs_t    hs;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [7:0]    fifo_rd_data;

    logic [7:0]    lq_mem [LEN_Q];
    logic [QW-1:0] lq_wr, lq_rd;
    logic [QW:0]   lq_cnt;

    logic [7:0] len_cnt, len_nxt;
    logic [7:0] len_r, rem_r;
`ifdef UART_FRAMER_CSUM_EN
    logic [7:0] sum_r;
`endif

    logic push, fifo_pop, lq_push, lq_pop, last_byte;

    assign in_ready     = (fifo_cnt != DEPTH_C) && (lq_cnt != LEN_Q_C);
    assign push         = in_valid && in_ready;
    assign len_nxt      = len_cnt + 8'd1;
    assign lq_push      = push && (in_last || (len_nxt == MAX_LEN_B));
    assign lq_pop       = (state == S_IDLE) && (lq_cnt != '0) && tx_ready;
    assign fifo_pop     = (hs == H_WAIT_HI) && tx_ready &&
                          ((state == S_LEN) || ((state == S_PAY) && (rem_r != 8'd0)));
    assign fifo_rd_data = fifo_mem[rd_ptr];
    assign busy         = (state != S_IDLE);
`ifdef UART_FRAMER_CSUM_EN
    assign last_byte    = (state == S_CSUM);
`else
    assign last_byte    = (state == S_PAY) && (rem_r == 8'd0);
`endif

    // Payload storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_data;
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Length queue storage.
    always_ff @(posedge clk) begin
        if (lq_push) lq_mem[lq_wr] <= len_nxt;
    end

    // Running packet length and length-queue pointers; a packet closes on in_last or at MAX_LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt <= '0;
            lq_wr   <= '0;
            lq_rd   <= '0;
            lq_cnt  <= '0;
        end else begin
            if (lq_push)   len_cnt <= '0;
            else if (push) len_cnt <= len_nxt;
            if (lq_push) lq_wr <= (lq_wr == LQ_LAST) ? '0 : lq_wr + 1'b1;
            if (lq_pop)  lq_rd <= (lq_rd == LQ_LAST) ? '0 : lq_rd + 1'b1;
            case ({lq_push, lq_pop})
                2'b10:   lq_cnt <= lq_cnt + 1'b1;
                2'b01:   lq_cnt <= lq_cnt - 1'b1;
                default: lq_cnt <= lq_cnt;
            endcase
        end
    end

    // Frame FSM with per-byte handshake; tx_data/tx_valid/frame_done are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hs         <= H_ISSUE;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            len_r      <= '0;
            rem_r      <= '0;
`ifdef UART_FRAMER_CSUM_EN
            sum_r      <= '0;
`endif
        end else begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            if (state == S_IDLE) begin
                if (lq_pop) begin
                    len_r    <= lq_mem[lq_rd];
                    rem_r    <= lq_mem[lq_rd];
`ifdef UART_FRAMER_CSUM_EN
                    sum_r    <= '0;
`endif
                    tx_data  <= SYNC_BYTE;
                    tx_valid <= 1'b1;
                    hs       <= H_ISSUE;
                    state    <= S_SYNC;
                end
            end else begin
                case (hs)
                    H_ISSUE: hs <= H_WAIT_LO;
                    H_WAIT_LO: begin
                        if (!tx_ready) begin
                            if (last_byte) begin
                                state      <= S_IDLE;
                                frame_done <= 1'b1;
                            end else begin
                                hs <= H_WAIT_HI;
                            end
                        end
                    end
                    H_WAIT_HI: begin
                        if (fifo_pop) begin
                            tx_data  <= fifo_rd_data;
                            tx_valid <= 1'b1;
                            rem_r    <= rem_r - 8'd1;
`ifdef UART_FRAMER_CSUM_EN
                            sum_r    <= sum_r + fifo_rd_data;
`endif
                            hs       <= H_ISSUE;
                            state    <= S_PAY;
                        end else if (tx_ready && (state == S_SYNC)) begin
                            tx_data  <= len_r;
                            tx_valid <= 1'b1;
`ifdef UART_FRAMER_CSUM_EN
                            sum_r    <= sum_r + len_r;
`endif
                            hs       <= H_ISSUE;
                            state    <= S_LEN;
                        end
`ifdef UART_FRAMER_CSUM_EN
                        else if (tx_ready && (state == S_PAY)) begin
                            tx_data  <= sum_r;
                            tx_valid <= 1'b1;
                            hs       <= H_ISSUE;
                            state    <= S_CSUM;
                        end
`endif
                    end
                    default: hs <= H_ISSUE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: a simple transmitter responder captures every
// issued byte, and each directed step compares against hand-derived frames.
// Frame expectations follow UART_FRAMER_CSUM_EN as compiled.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_mis = 0;

    logic       tx_stall = 1'b0;
    int         hold     = 0;
    logic       prev_v   = 1'b0;
    int         fd_cnt   = 0;
    logic [7:0] cap [$];
    logic [7:0] exp_q [$];

    uart_tx_framer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Transmitter model: takes a byte on tx_valid, stays busy a few cycles, then idles.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold     = 0;
            tx_ready = !tx_stall;
            prev_v   = 1'b0;
        end else begin
            if (tx_valid) begin
                chk("valid_gap", {31'd0, prev_v}, 32'd0);
                cap.push_back(tx_data);
                tx_ready = 1'b0;
                hold     = 3;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) tx_ready = !tx_stall;
            end else begin
                tx_ready = !tx_stall;
            end
            prev_v = tx_valid;
            if (frame_done) fd_cnt++;
        end
    end

    task automatic push(input logic [7:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("push_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic void add_frame(input logic [7:0] first, input int len);
        logic [7:0] s;
        logic [7:0] b;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(len));
        s = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = first + 8'(i);
            exp_q.push_back(b);
            s = s + b;
        end
`ifdef UART_FRAMER_CSUM_EN
        exp_q.push_back(s);
`endif
    endfunction

    task automatic check_frames(input string tag, input int n_frames);
        int t = 0;
        while (cap.size() < exp_q.size() && t < 6000) begin
            @(negedge clk);
            t++;
        end
        repeat (30) @(negedge clk);
        chk({tag, "_nbytes"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, cap[i]}, {24'd0, exp_q[i]});
        chk({tag, "_frame_done"}, fd_cnt, n_frames);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        cap.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        int t;
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Reset values
        #12;
        chk("rst_tx_valid",   {31'd0, tx_valid},   32'd0);
        chk("rst_tx_data",    {24'd0, tx_data},    32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        fd_cnt = 0;

        // Basic frame and input-to-output latency
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b1);
        @(negedge clk);
        chk("lat_edge_n", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        chk("lat_edge_n1_valid", {31'd0, tx_valid}, 32'd1);
        chk("lat_edge_n1_data",  {24'd0, tx_data},  32'hA5);
        chk("lat_busy",          {31'd0, busy},     32'd1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
`ifdef UART_FRAMER_CSUM_EN
        exp_q.push_back(8'h09);
`endif
        check_frames("basic", 1);

        // Auto-split: 40 bytes, in_last only on 0x27 -> len 0x20 (csum 0x10), len 0x08 (csum 0x24)
        for (int i = 0; i < 40; i++) push(8'(i), (i == 39));
        add_frame(8'h00, 32);
        add_frame(8'h20, 8);
        check_frames("split", 2);

        // Backpressure: stalled transmitter, 64 bytes fill the FIFO
        @(negedge clk);
        tx_stall = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 32; i++) push(8'h40 + 8'(i), (i == 31));
        for (int i = 0; i < 32; i++) push(8'h60 + 8'(i), 1'b0);
        @(negedge clk);
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        repeat (5) @(negedge clk);
        chk("bp_no_tx", cap.size(), 0);
        chk("bp_idle",  {31'd0, busy}, 32'd0);
        tx_stall = 1'b0;
        add_frame(8'h40, 32);
        add_frame(8'h60, 32);
        check_frames("bp", 2);

        // Length queue full: four one-byte packets against a stalled transmitter
        @(negedge clk);
        tx_stall = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i), 1'b1);
        @(negedge clk);
        chk("qf_in_ready", {31'd0, in_ready}, 32'd0);
        in_data  = 8'hB4;
        in_valid = 1'b1;
        in_last  = 1'b1;
        repeat (5) @(negedge clk);
        chk("qf_still_blocked", {31'd0, in_ready}, 32'd0);
        chk("qf_no_tx", cap.size(), 0);
        tx_stall = 1'b0;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("qf_ready_after_pop", {31'd0, in_ready}, 32'd1);
        chk("qf_busy_after_pop",  {31'd0, busy},     32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) add_frame(8'hB0 + 8'(i), 1);
        check_frames("qf", 5);

        // Asynchronous reset in the middle of the payload
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i), (i == 4));
        t = 0;
        while (!(tx_valid && tx_data == 8'h12) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reach_pay", {24'd0, tx_data}, 32'h12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_busy",     {31'd0, busy},     32'd0);
        chk("mid_rst_tx_data",  {24'd0, tx_data},  32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cap.delete();
        fd_cnt = 0;
        push(8'h7E, 1'b1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h7E);
`ifdef UART_FRAMER_CSUM_EN
        exp_q.push_back(8'h7F);
`endif
        check_frames("post_rst", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
